// File: rtl/regfile_multiport_sb.sv
// Multi-way register file with a per-register busy scoreboard.
// Ports: rsN_addr/rsN_data/rsN_busy per way, wr_* writeback, iss_* issue marks, busy_vec.
module regfile_multiport_sb #(
    parameter int NUM_WAYS = 2,
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_WAYS-1:0][AW-1:0]        rs1_addr,
    input  logic [NUM_WAYS-1:0][AW-1:0]        rs2_addr,
    output logic [NUM_WAYS-1:0][XLEN-1:0]      rs1_data,
    output logic [NUM_WAYS-1:0][XLEN-1:0]      rs2_data,
    output logic [NUM_WAYS-1:0]                rs1_busy,
    output logic [NUM_WAYS-1:0]                rs2_busy,
    input  logic [NUM_WAYS-1:0]                wr_en,
    input  logic [NUM_WAYS-1:0][AW-1:0]        wr_addr,
    input  logic [NUM_WAYS-1:0][XLEN-1:0]      wr_data,
    input  logic [NUM_WAYS-1:0]                iss_en,
    input  logic [NUM_WAYS-1:0][AW-1:0]        iss_rd,
    output logic [NREG-1:0]                    busy_vec
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Ascending way order lets the youngest way win address conflicts.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NUM_WAYS; k++) begin
            if (wr_en[k] && wr_addr[k] != '0) begin
                regs_d[wr_addr[k]] = wr_data[k];
            end
        end
    end

    // Clears applied first, then sets, so a new issue beats a completing write.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NUM_WAYS; k++) begin
            if (wr_en[k]) begin
                busy_d[wr_addr[k]] = 1'b0;
            end
        end
        for (int k = 0; k < NUM_WAYS; k++) begin
            if (iss_en[k]) begin
                busy_d[iss_rd[k]] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            hit;
        logic            b;
        rs1_data = '0;
        rs2_data = '0;
        rs1_busy = '0;
        rs2_busy = '0;
        for (int j = 0; j < NUM_WAYS; j++) begin
            for (int s = 0; s < 2; s++) begin
                a   = (s == 0) ? rs1_addr[j] : rs2_addr[j];
                d   = regs_q[a];
                hit = 1'b0;
                for (int k = 0; k < NUM_WAYS; k++) begin
                    if (BYPASS != 0 && wr_en[k] && wr_addr[k] == a) begin
                        d   = wr_data[k];
                        hit = 1'b1;
                    end
                end
                b = busy_q[a] && !hit;
                // Only older ways in the bundle create a RAW hazard.
                for (int i = 0; i < j; i++) begin
                    if (iss_en[i] && iss_rd[i] == a) begin
                        b = 1'b1;
                    end
                end
                if (a == '0) begin
                    d = '0;
                    b = 1'b0;
                end
                if (s == 0) begin
                    rs1_data[j] = d;
                    rs1_busy[j] = b;
                end else begin
                    rs2_data[j] = d;
                    rs2_busy[j] = b;
                end
            end
        end
    end

    assign busy_vec = busy_q;

endmodule
